fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction prefetch buffer between instruction memory and decode.
- Accepts up to two fetched instructions per cycle, matching the two-wide instruction memory read port.
- Delivers one instruction per cycle, with its PC, to the decode/ID stage.
- Absorbs decode stalls and discards all contents on a branch flush.

Parameters:
- INST_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 16, PC width.
- DEPTH, 4, queue entries; power of two, minimum 2.
- PC_STEP, 1, PC increment between consecutive instructions (word-addressed).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  branch taken; discard all entries.
- fetch_valid0  input  1  fetch_inst0 is valid.
- fetch_valid1  input  1  fetch_inst1 is valid; ignored unless fetch_valid0=1.
- fetch_pc  input  ADDR_WIDTH  PC of fetch_inst0.
- fetch_inst0  input  INST_WIDTH  instruction at fetch_pc.
- fetch_inst1  input  INST_WIDTH  instruction at fetch_pc+PC_STEP.
- fetch_ready  output  1  at least 2 free entries.
- dec_ready  input  1  decode accepts this cycle (driven as !stall).
- dec_valid  output  1  queue non-empty.
- dec_instruction  output  INST_WIDTH  head instruction; 0 (NOP) when empty.
- dec_pc  output  ADDR_WIDTH  PC of head entry; 0 when empty.
- occupancy  output  log2(DEPTH)+1  current entry count.

Behaviour:
- Storage:
  - Circular array of {pc, instruction}.
  - head_ptr and tail_ptr, each log2(DEPTH) bits, wrapping modulo DEPTH.
  - count, log2(DEPTH)+1 bits, range 0..DEPTH.
- Reset (async, immediate):
  - count=0, head_ptr=0, tail_ptr=0.
  - dec_valid=0, dec_instruction=0, dec_pc=0, fetch_ready=1, occupancy=0.
  - Array contents need not be cleared.
- fetch_ready = (DEPTH - count) >= 2. Combinational from count only; no dependency on same-cycle dequeue.
- Enqueue, only when fetch_ready=1 and flush=0:
  - n_in = fetch_valid0 + (fetch_valid0 & fetch_valid1).
  - Entry at tail_ptr gets {fetch_pc, fetch_inst0}.
  - If n_in=2, entry at tail_ptr+1 gets {fetch_pc+PC_STEP, fetch_inst1}. PC addition wraps modulo 2^ADDR_WIDTH.
  - tail_ptr += n_in.
  - fetch_valid* asserted while fetch_ready=0: data dropped, no state change. Upstream must hold its PC.
- Dequeue: n_out = dec_valid & dec_ready & !flush. head_ptr += n_out.
- count_next = count + n_in - n_out.
  - Simultaneous enqueue and dequeue in the same cycle is legal.
  - count can never exceed DEPTH, because fetch_ready requires 2 free entries.
- Outputs:
  - dec_valid = (count != 0).
  - dec_instruction and dec_pc = entry at head_ptr when count != 0, else 0.
  - Combinational read of registered state; no bypass.
  - An enqueued instruction is visible on dec_* the cycle after the enqueuing edge (latency 1).
- Flush:
  - Highest priority. At the clock edge: count=0, head_ptr=0, tail_ptr=0.
  - Same-cycle fetch data and dequeue are discarded.
  - Next cycle dec_valid=0 and fetch_ready=1.
- Stall (dec_ready=0): head entry and dec_* outputs hold stable; enqueue continues while space remains.
- Ordering: strict FIFO. Inst0 always precedes inst1 of the same fetch.
- Reset asserted mid-operation: all state cleared asynchronously regardless of flush or handshake inputs.
- occupancy = count.

Test Plan:
- Reset then idle: assert reset with fetch_valid0=1 → dec_valid=0, dec_instruction=0, fetch_ready=1, occupancy=0 throughout reset.
- Dual enqueue and drain:
  - Stimulus: fetch_pc=0x0010, inst0=0xAAAA0001, inst1=0xBBBB0002, both valid; dec_ready=1.
  - Response: next cycle dec_pc=0x0010 / 0xAAAA0001; following cycle dec_pc=0x0011 / 0xBBBB0002; then dec_valid=0.
- Fill with stall:
  - Stimulus: dec_ready=0; two dual fetches at pc 0x0000 and 0x0002.
  - Response: occupancy=4, fetch_ready=0; a third fetch with valid=1 is dropped; dec_pc holds 0x0000.
  - Then dec_ready=1 → outputs PCs 0,1,2,3 in order.
- Simultaneous enqueue and dequeue at occupancy 2: single-valid fetch plus dequeue in the same cycle → occupancy stays 2, order preserved.
- Flush while full:
  - Stimulus: occupancy=4, flush=1 together with a valid fetch and dec_ready=1.
  - Response: next cycle occupancy=0, dec_valid=0, fetch_ready=1; the flushed-cycle fetch is never delivered.
- Pointer wrap and PC wrap:
  - Stimulus: ten dual fetches with continuous drain, then one fetch with fetch_pc=0xFFFF.
  - Response: correct FIFO order across head/tail wrap; second entry dec_pc=0x0000.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
interface fetch_queue_if #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  fetch_valid0;
    logic                  fetch_valid1;
    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [INST_WIDTH-1:0] fetch_inst0;
    logic [INST_WIDTH-1:0] fetch_inst1;
    logic                  fetch_ready;
    logic                  dec_ready;
    logic                  dec_valid;
    logic [INST_WIDTH-1:0] dec_instruction;
    logic [ADDR_WIDTH-1:0] dec_pc;
    logic [CW-1:0]         occupancy;

    modport master (
        output flush, fetch_valid0, fetch_valid1,
        output fetch_pc, fetch_inst0, fetch_inst1,
        output dec_ready,
        input  fetch_ready, dec_valid, dec_instruction,
        input  dec_pc, occupancy
    );

    modport slave (
        input  flush, fetch_valid0, fetch_valid1,
        input  fetch_pc, fetch_inst0, fetch_inst1,
        input  dec_ready,
        output fetch_ready, dec_valid, dec_instruction,
        output dec_pc, occupancy
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: two-wide enqueue from imem,
// one-wide dequeue to decode, flushed on taken branch.
module fetch_queue #(
    parameter int INST_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int PC_STEP    = 1
) (
    input logic         clk,
    input logic         reset,
    fetch_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
    } entry_t;

    entry_t        mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic [CW-1:0] count;
    logic          enq_ok;
    logic          wr0;
    logic          wr1;
    logic [1:0]    n_in;
    logic          n_out;

    // Space for a full two-wide fetch is judged from count alone.
    assign bus.fetch_ready = (DEPTH_C - count) >= CW'(2);
    assign enq_ok = bus.fetch_ready & ~bus.flush;
    assign wr0    = enq_ok & bus.fetch_valid0;
    assign wr1    = wr0 & bus.fetch_valid1;
    assign n_in   = {1'b0, wr0} + {1'b0, wr1};

    assign bus.dec_valid = (count != '0);
    assign n_out = bus.dec_valid & bus.dec_ready & ~bus.flush;

    assign bus.dec_instruction = bus.dec_valid ? mem[head_ptr].inst : '0;
    assign bus.dec_pc          = bus.dec_valid ? mem[head_ptr].pc   : '0;
    assign bus.occupancy       = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (bus.flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            head_ptr <= head_ptr + PW'(n_out);
            tail_ptr <= tail_ptr + PW'(n_in);
            count    <= count + CW'(n_in) - CW'(n_out);
        end
    end

    // Storage is not reset; count gates every read.
    always_ff @(posedge clk) begin
        if (wr0) begin
            mem[tail_ptr] <= '{pc: bus.fetch_pc, inst: bus.fetch_inst0};
        end
        if (wr1) begin
            mem[tail_ptr + PW'(1)] <= '{
                pc:   bus.fetch_pc + ADDR_WIDTH'(PC_STEP),
                inst: bus.fetch_inst1
            };
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, dual enqueue, stall fill,
// concurrent enq/deq, flush, pointer and PC wrap.
module tb_fetch_queue;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fetch_queue_if #(.INST_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(4)) bus ();

    fetch_queue #(
        .INST_WIDTH(32), .ADDR_WIDTH(16), .DEPTH(4), .PC_STEP(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic v0, input logic v1,
                         input logic [15:0] pc,
                         input logic [31:0] i0, input logic [31:0] i1);
        bus.fetch_valid0 = v0;
        bus.fetch_valid1 = v1;
        bus.fetch_pc     = pc;
        bus.fetch_inst0  = i0;
        bus.fetch_inst1  = i1;
    endtask

    task automatic idle();
        fetch(1'b0, 1'b0, 16'h0, 32'h0, 32'h0);
    endtask

    task automatic head(input string tag, input logic [15:0] pc,
                        input logic [31:0] inst);
        check({tag, "_v"}, bus.dec_valid, 1);
        check({tag, "_pc"}, bus.dec_pc, pc);
        check({tag, "_in"}, bus.dec_instruction, inst);
    endtask

    task automatic empty(input string tag);
        check({tag, "_v"}, bus.dec_valid, 0);
        check({tag, "_pc"}, bus.dec_pc, 0);
        check({tag, "_in"}, bus.dec_instruction, 0);
        check({tag, "_occ"}, bus.occupancy, 0);
        check({tag, "_rdy"}, bus.fetch_ready, 1);
    endtask

    logic [15:0] eq_pc[$];
    logic [31:0] eq_in[$];
    int          issued;
    int          cyc;
    logic        model_rdy;
    logic        had;

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.dec_ready = 1'b0;
        fetch(1'b1, 1'b1, 16'h1234, 32'h11111111, 32'h22222222);
        #1;
        empty("rst0");
        step();
        empty("rst1");
        step();
        empty("rst2");
        idle();
        #3 reset = 1'b0;
        step();
        empty("idle");

        // dual enqueue and drain
        bus.dec_ready = 1'b1;
        fetch(1'b1, 1'b1, 16'h0010, 32'hAAAA0001, 32'hBBBB0002);
        step();
        idle();
        head("dual0", 16'h0010, 32'hAAAA0001);
        check("dual0_occ", bus.occupancy, 2);
        step();
        head("dual1", 16'h0011, 32'hBBBB0002);
        check("dual1_occ", bus.occupancy, 1);
        step();
        empty("dual_end");

        // fill with stall
        bus.dec_ready = 1'b0;
        fetch(1'b1, 1'b1, 16'h0000, 32'h100, 32'h101);
        step();
        fetch(1'b1, 1'b1, 16'h0002, 32'h102, 32'h103);
        step();
        check("full_occ", bus.occupancy, 4);
        check("full_rdy", bus.fetch_ready, 0);
        head("full_hd", 16'h0000, 32'h100);
        fetch(1'b1, 1'b1, 16'h0008, 32'hDEAD, 32'hBEEF);
        step();
        idle();
        check("drop_occ", bus.occupancy, 4);
        head("drop_hd", 16'h0000, 32'h100);
        bus.dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            head($sformatf("drain%0d", i), 16'(i), 32'(32'h100 + i));
            step();
        end
        empty("drain_end");

        // concurrent enqueue and dequeue at occupancy 2
        bus.dec_ready = 1'b0;
        fetch(1'b1, 1'b1, 16'h0020, 32'h200, 32'h201);
        step();
        check("sim_occ0", bus.occupancy, 2);
        bus.dec_ready = 1'b1;
        fetch(1'b1, 1'b0, 16'h0030, 32'h300, 32'h0);
        step();
        idle();
        check("sim_occ1", bus.occupancy, 2);
        head("sim_a", 16'h0021, 32'h201);
        step();
        head("sim_b", 16'h0030, 32'h300);
        step();
        empty("sim_end");

        // flush while full
        bus.dec_ready = 1'b0;
        fetch(1'b1, 1'b1, 16'h0040, 32'h400, 32'h401);
        step();
        fetch(1'b1, 1'b1, 16'h0042, 32'h402, 32'h403);
        step();
        check("fl_occ4", bus.occupancy, 4);
        bus.flush = 1'b1;
        bus.dec_ready = 1'b1;
        fetch(1'b1, 1'b1, 16'h0050, 32'h500, 32'h501);
        step();
        bus.flush = 1'b0;
        idle();
        empty("fl_full");
        step();
        empty("fl_full2");

        // flush with space: same-cycle fetch must be discarded
        fetch(1'b1, 1'b0, 16'h0060, 32'h600, 32'h0);
        bus.dec_ready = 1'b0;
        step();
        check("fl1_occ", bus.occupancy, 1);
        bus.flush = 1'b1;
        fetch(1'b1, 1'b1, 16'h0070, 32'h700, 32'h701);
        step();
        bus.flush = 1'b0;
        idle();
        empty("fl_part");

        // ten dual fetches with continuous drain; upstream holds PC
        bus.dec_ready = 1'b1;
        issued = 0;
        cyc = 0;
        while ((issued < 10 || eq_pc.size() != 0) && cyc < 80) begin
            had = (eq_pc.size() != 0);
            model_rdy = (4 - eq_pc.size()) >= 2;
            check("wr_v", bus.dec_valid, had);
            check("wr_rdy", bus.fetch_ready, model_rdy);
            check("wr_occ", bus.occupancy, eq_pc.size());
            if (had) begin
                check("wr_pc", bus.dec_pc, eq_pc[0]);
                check("wr_in", bus.dec_instruction, eq_in[0]);
            end
            if (issued < 10)
                fetch(1'b1, 1'b1, 16'(16'h0100 + 2 * issued),
                      32'(32'h1000 + 2 * issued),
                      32'(32'h1001 + 2 * issued));
            else
                idle();
            step();
            if (had) begin
                void'(eq_pc.pop_front());
                void'(eq_in.pop_front());
            end
            if (issued < 10 && model_rdy) begin
                eq_pc.push_back(16'(16'h0100 + 2 * issued));
                eq_pc.push_back(16'(16'h0101 + 2 * issued));
                eq_in.push_back(32'(32'h1000 + 2 * issued));
                eq_in.push_back(32'(32'h1001 + 2 * issued));
                issued++;
            end
            cyc++;
        end
        idle();
        check("wr_done", (issued == 10) && (eq_pc.size() == 0), 1);
        empty("wr_end");

        // PC wrap on the second slot
        bus.dec_ready = 1'b0;
        fetch(1'b1, 1'b1, 16'hFFFF, 32'hF00D0000, 32'hF00D0001);
        step();
        idle();
        head("pcw0", 16'hFFFF, 32'hF00D0000);
        bus.dec_ready = 1'b1;
        step();
        head("pcw1", 16'h0000, 32'hF00D0001);
        step();
        empty("pcw_end");

        // async reset mid-operation
        fetch(1'b1, 1'b1, 16'h0090, 32'h900, 32'h901);
        bus.dec_ready = 1'b0;
        step();
        idle();
        check("ar_occ", bus.occupancy, 2);
        #2 reset = 1'b1;
        #1;
        empty("ar");
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
